// File: rtl/video_timing_generator.sv
// Free-running raster timing source: one pixel per clock, registered strobes and coordinates.
// Defaults produce 640x480@60 (800x525 total) with active-low syncs.
module video_timing_generator #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  output logic          visible_o,
  output logic          hsync_n_o,
  output logic          vsync_n_o,
  output logic          end_of_line_o,
  output logic          end_of_frame_o,
  output logic [HW-1:0] x_o,
  output logic [VW-1:0] y_o,
  output logic [7:0]    frame_o
);

  localparam logic [HW-1:0] H_VIS_END    = HW'(H_VISIBLE);
  localparam logic [HW-1:0] H_SYNC_START = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_END    = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_SYNC_START = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [7:0]    frame_cnt;
  logic          h_last;
  logic          v_last;

  assign h_last = (h == H_LAST);
  assign v_last = (v == V_LAST);

  // No back-pressure: downstream consumes exactly one pixel per clock, always.
  // Outputs decode the counters as held before the edge, so every output
  // (including frame_o) describes the same pixel.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      h              <= '0;
      v              <= '0;
      frame_cnt      <= '0;
      visible_o      <= 1'b0;
      hsync_n_o      <= 1'b1;
      vsync_n_o      <= 1'b1;
      end_of_line_o  <= 1'b0;
      end_of_frame_o <= 1'b0;
      x_o            <= '0;
      y_o            <= '0;
      frame_o        <= '0;
    end else begin
      visible_o      <= (h < H_VIS_END) && (v < V_VIS_END);
      hsync_n_o      <= !((h >= H_SYNC_START) && (h < H_SYNC_END));
      vsync_n_o      <= !((v >= V_SYNC_START) && (v < V_SYNC_END));
      end_of_line_o  <= h_last;
      end_of_frame_o <= h_last && v_last;
      x_o            <= h;
      y_o            <= v;
      frame_o        <= frame_cnt;

      if (h_last) begin
        h <= '0;
        if (v_last) begin
          v         <= '0;
          frame_cnt <= frame_cnt + 8'd1;
        end else begin
          v <= v + 1'b1;
        end
      end else begin
        h <= h + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_generator.sv
// Bench for video_timing_generator: default 640x480 instance for line-level behaviour,
// tiny-raster instance for frame-level behaviour and frame counter wrap.
module tb_video_timing_generator;

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb;
  } cfg_t;

  typedef struct packed {
    logic [7:0]  frame;
    logic [15:0] x;
    logic [15:0] y;
    logic        vis;
    logic        hs_n;
    logic        vs_n;
    logic        eol;
    logic        eof;
  } pix_t;

  localparam int PW = $bits(pix_t);

  typedef struct {
    int t;
    int x;
    int y;
    bit vis;
    bit hs_n;
    bit eol;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d = 1'b0;
  logic rst_s = 1'b0;

  logic       vis_d, hs_d, vs_d, eol_d, eof_d;
  logic [9:0] x_d, y_d;
  logic [7:0] frame_d;

  logic       vis_s, hs_s, vs_s, eol_s, eof_s;
  logic [2:0] x_s, y_s;
  logic [7:0] frame_s;

  video_timing_generator dut_d (
    .clk_i(clk), .rst_n_i(rst_d),
    .visible_o(vis_d), .hsync_n_o(hs_d), .vsync_n_o(vs_d),
    .end_of_line_o(eol_d), .end_of_frame_o(eof_d),
    .x_o(x_d), .y_o(y_d), .frame_o(frame_d)
  );

  video_timing_generator #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dut_s (
    .clk_i(clk), .rst_n_i(rst_s),
    .visible_o(vis_s), .hsync_n_o(hs_s), .vsync_n_o(vs_s),
    .end_of_line_o(eol_s), .end_of_frame_o(eof_s),
    .x_o(x_s), .y_o(y_s), .frame_o(frame_s)
  );

  // scoreboard state
  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [PW-1:0] exp_q[$];
  cfg_t cfg_d, cfg_s;
  vec_t vec[12];

  // Reference: pixel position follows from elapsed cycles since reset release.
  function automatic pix_t model(input cfg_t c, input int t);
    pix_t r;
    int ht = c.hv + c.hf + c.hs + c.hb;
    int vt = c.vv + c.vf + c.vs + c.vb;
    int n  = ht * vt;
    int p  = t % n;
    int x  = p % ht;
    int y  = p / ht;
    r.frame = 8'((t / n) % 256);
    r.x     = 16'(x);
    r.y     = 16'(y);
    r.vis   = (x < c.hv) && (y < c.vv);
    r.hs_n  = !((x >= c.hv + c.hf) && (x < c.hv + c.hf + c.hs));
    r.vs_n  = !((y >= c.vv + c.vf) && (y < c.vv + c.vf + c.vs));
    r.eol   = (x == ht - 1);
    r.eof   = r.eol && (y == vt - 1);
    return r;
  endfunction

  function automatic pix_t reset_pix();
    pix_t r = '0;
    r.hs_n = 1'b1;
    r.vs_n = 1'b1;
    return r;
  endfunction

  function automatic pix_t obs_d();
    pix_t r;
    r.frame = frame_d; r.x = 16'(x_d); r.y = 16'(y_d);
    r.vis = vis_d; r.hs_n = hs_d; r.vs_n = vs_d; r.eol = eol_d; r.eof = eof_d;
    return r;
  endfunction

  function automatic pix_t obs_s();
    pix_t r;
    r.frame = frame_s; r.x = 16'(x_s); r.y = 16'(y_s);
    r.vis = vis_s; r.hs_n = hs_s; r.vs_n = vs_s; r.eol = eol_s; r.eof = eof_s;
    return r;
  endfunction

  task automatic check_pix(input string name, input pix_t act, input pix_t exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got x=%0d y=%0d f=%0d vis=%0b hs_n=%0b vs_n=%0b eol=%0b eof=%0b; expected x=%0d y=%0d f=%0d vis=%0b hs_n=%0b vs_n=%0b eol=%0b eof=%0b",
               name, act.x, act.y, act.frame, act.vis, act.hs_n, act.vs_n, act.eol, act.eof,
               exp.x, exp.y, exp.frame, exp.vis, exp.hs_n, exp.vs_n, exp.eol, exp.eof);
    end else begin
      passes++;
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      passes++;
    end
  endtask

  // driver tasks: one pixel step, expectation queued before the edge, checked after
  task automatic step_d(input int t);
    exp_q.push_back(model(cfg_d, t));
    @(negedge clk);
    check_pix("pixel_d", obs_d(), pix_t'(exp_q.pop_front()));
  endtask

  task automatic step_s(input int t);
    exp_q.push_back(model(cfg_s, t));
    @(negedge clk);
    check_pix("pixel_s", obs_s(), pix_t'(exp_q.pop_front()));
  endtask

  task automatic reset_s(input int cycles);
    rst_s = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      check_pix("reset_s", obs_s(), reset_pix());
    end
    rst_s = 1'b1;
  endtask

  task automatic reset_d(input int cycles);
    rst_d = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      check_pix("reset_d", obs_d(), reset_pix());
    end
    rst_d = 1'b1;
  endtask

  initial begin
    int k, last_eol, vis_run, first_eol, last_eof, vs_low, vis_cnt, wrap_seen;
    int prev_frame, n_run;
    logic prev_hs;
    pix_t vp;

    cfg_d = '{640, 16, 96, 48, 480, 10, 2, 33};
    cfg_s = '{4, 1, 1, 1, 3, 1, 1, 1};

    // t, x, y, visible, hsync_n, end_of_line (first three lines, frame 0)
    vec[0]  = '{0,    0,   0, 1, 1, 0};
    vec[1]  = '{639,  639, 0, 1, 1, 0};
    vec[2]  = '{640,  640, 0, 0, 1, 0};
    vec[3]  = '{655,  655, 0, 0, 1, 0};
    vec[4]  = '{656,  656, 0, 0, 0, 0};
    vec[5]  = '{751,  751, 0, 0, 0, 0};
    vec[6]  = '{752,  752, 0, 0, 1, 0};
    vec[7]  = '{799,  799, 0, 0, 1, 1};
    vec[8]  = '{800,  0,   1, 1, 1, 0};
    vec[9]  = '{1599, 799, 1, 0, 1, 1};
    vec[10] = '{2256, 656, 2, 0, 0, 0};
    vec[11] = '{2399, 799, 2, 0, 1, 1};

    // reset held on both instances
    repeat (5) begin
      @(negedge clk);
      check_pix("reset_hold_d", obs_d(), reset_pix());
      check_pix("reset_hold_s", obs_s(), reset_pix());
    end

    // default raster: three lines plus table vectors and line measurements
    rst_d = 1'b1;
    k = 0; last_eol = -1; vis_run = 0; prev_hs = 1'b1;
    for (int i = 0; i < 2400; i++) begin
      step_d(i);
      if (k < 12 && vec[k].t == i) begin
        vp = '0;
        vp.x = 16'(vec[k].x); vp.y = 16'(vec[k].y);
        vp.vis = vec[k].vis; vp.hs_n = vec[k].hs_n; vp.vs_n = 1'b1;
        vp.eol = vec[k].eol;
        check_pix($sformatf("vec_%0d", k), obs_d(), vp);
        k++;
      end
      if (eol_d) begin
        if (last_eol >= 0) check_int("eol_period", i - last_eol, 800);
        last_eol = i;
      end
      if (!hs_d && prev_hs) check_int("hsync_start_x", int'(x_d), 656);
      prev_hs = hs_d;
      if (vis_d) vis_run++;
      else if (vis_run > 0) begin
        check_int("visible_run", vis_run, 640);
        vis_run = 0;
      end
    end
    check_int("vectors_applied", k, 12);

    // mid-line reset at x=700, y=3, then restart from (0,0)
    for (int i = 2400; i <= 3100; i++) step_d(i);
    reset_d(1);
    first_eol = -1;
    for (int i = 0; i < 900; i++) begin
      step_d(i);
      if (eol_d && first_eol < 0) first_eol = i + 1;
    end
    check_int("eol_after_release", first_eol, 800);

    // tiny raster: 260 frames, frame counter wraps 255 -> 0
    rst_s = 1'b1;
    last_eof = -1; vs_low = 0; vis_cnt = 0; wrap_seen = 0; prev_frame = 0;
    for (int i = 0; i < 260 * 42 + 20; i++) begin
      step_s(i);
      if (!vs_s) vs_low++;
      if (vis_s) vis_cnt++;
      if (prev_frame == 255 && frame_s == 8'd0) wrap_seen++;
      prev_frame = int'(frame_s);
      if (eof_s) begin
        if (last_eof >= 0) check_int("eof_period", i - last_eof, 42);
        last_eof = i;
        check_int("eof_with_eol", int'(eol_s), 1);
        check_int("eof_xy", int'(x_s) * 8 + int'(y_s), 6 * 8 + 5);
        check_int("vsync_low_cycles", vs_low, 7);
        check_int("visible_cycles", vis_cnt, 12);
        vs_low = 0;
        vis_cnt = 0;
      end
    end
    check_int("frame_wrap_seen", wrap_seen, 1);

    // random reset points on both instances
    for (int r = 0; r < 8; r++) begin
      reset_s($urandom_range(1, 3));
      n_run = $urandom_range(1, 120);
      for (int i = 0; i < n_run; i++) step_s(i);
    end
    reset_s(1);
    for (int i = 0; i < 50; i++) step_s(i);

    for (int r = 0; r < 4; r++) begin
      reset_d($urandom_range(1, 3));
      n_run = $urandom_range(1, 1000);
      for (int i = 0; i < n_run; i++) step_d(i);
    end

    check_int("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
